ws_array_feeder: RTL and testbench
==================================

// Module: ws_array_feeder
// PURPOSE
//  Upstream sequencer for a weight-stationary PE column of ROWS chained PEs.
//  - Accepts a weight stream and an activation-vector stream over valid/ready.
//  - Drives the column's control code and top d_in: weight load first, then zero psum seed.
//  - Drives per-row activations skewed by row index; signals done after the skew drains.
// PARAMETERS
//  WORD_WIDTH  8   activation/weight width; psum width is 4*WORD_WIDTH
//  ROWS        4   PEs in the column; weights per load; activation lanes
//  CNT_WIDTH   8   width of vec_count
// PORTS
//  clk        in   1                 single clock, rising edge
//  reset      in   1                 synchronous, active-high
//  start      in   1                 pulse: begin job (ignored unless IDLE)
//  vec_count  in   CNT_WIDTH         activation vectors in job, latched on start
//  w_valid    in   1                 weight available
//  w_ready    out  1                 weight accepted when w_valid&w_ready
//  w_data     in   WORD_WIDTH        weight; first accepted = deepest PE
//  a_valid    in   1                 activation vector available
//  a_ready    out  1                 vector accepted when a_valid&a_ready
//  a_data     in   ROWS*WORD_WIDTH   lane r = bits [r*W +: W]
//  control    out  2                 00 hold/idle, 01 load weight, 10 compute
//  d_in       out  4*WORD_WIDTH      top-of-column data/psum seed
//  a_in       out  ROWS*WORD_WIDTH   skewed activations, lane r -> PE row r
//  a_in_vld   out  ROWS              lane r carries a real (non-bubble) value
//  busy       out  1                 state != IDLE
//  done       out  1                 one-cycle pulse at job end
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, skew regs 0; takes effect at the next edge, aborting any job.
//  - All outputs registered; a handshake at edge k is visible on outputs after edge k.
//  - IDLE: w_ready=a_ready=0, control=00.
//    start=1 -> latch vec_count, go to LOAD.
//  - LOAD: w_ready=1, weight counter 0..ROWS-1.
//    - Accepted weight: control=01, d_in=zero-extended w_data, for exactly that cycle.
//    - No weight offered: control=00 (bubble), d_in unchanged; the PE must hold.
//    - On the ROWS-th accept go to COMPUTE, or to DRAIN if vec_count==0.
//  - COMPUTE: a_ready=1, control=10, d_in=0.
//    - Skew: lane 0 delay 0, lane r delay r cycles (r-stage shift per lane).
//    - Accepted vector enters the skew with vld=1; a cycle without one enters zeros with vld=0.
//    - The vector counter reaches vec_count -> DRAIN.
//  - DRAIN: control=10, a_ready=0, zeros/vld=0 enter the skew for ROWS-1 cycles.
//    - done=1 on the final DRAIN cycle, then IDLE.
//    - vec_count==0: DRAIN still runs ROWS-1 cycles.
//  - start while busy: ignored.
//  - w_valid outside LOAD and a_valid outside COMPUTE: ignored (ready=0).
//  - Counters never wrap within a job.
//    - vec_count is at most 2^CNT_WIDTH-1.
//    - Weight counter saturates at ROWS; it resets in IDLE.
//  - Latency: start at edge t -> w_ready=1 after edge t+1.
//    - With no bubbles, done = 1 + ROWS + vec_count + ROWS-1 cycles after start.
// CONFIGURATION
//  FEEDER_STALL_CNT_EN defined:
//    - Adds output stall_cnt [15:0], saturating.
//    - Counts LOAD cycles with w_valid=0 plus COMPUTE cycles with a_valid=0.
//    - Cleared on start and on reset; holds its value after done.
//  FEEDER_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (ROWS=4, WORD_WIDTH=8)
//  1 Reset mid-LOAD after 2 weights
//      -> next cycle busy=0, control=00, a_in=0.
//      -> A new start loads 4 fresh weights.
//  2 start, vec_count=1, weights 3,4,5,6 back-to-back
//      -> control=01 four cycles with d_in=3,4,5,6, then control=10.
//  3 Vector {lane3..0}={8,7,6,5} accepted at edge k
//      -> lane0=5 after k, lane1=6 after k+1, lane2=7 after k+2, lane3=8 after k+3, each with vld=1.
//  4 w_valid toggling 1,0,1,0,1,1
//      -> control=01,00,01,00,01,01; exactly 4 loads; stall_cnt=2 with FEEDER_STALL_CNT_EN.
//  5 vec_count=0
//      -> LOAD 4 weights, 3 DRAIN cycles, done pulse, a_ready never 1.
//  6 start asserted again during COMPUTE
//      -> no effect; vec_count latch unchanged; single done pulse.

Source files
------------

// File: rtl/ws_array_feeder.sv
// ws_array_feeder: upstream sequencer for a weight-stationary PE column.
// Loads ROWS weights down the column, then streams activation vectors with a
// per-row skew (lane r delayed r cycles), drains the skew and pulses done.
// Optional build macro: FEEDER_STALL_CNT_EN adds a saturating stall_cnt output
// counting cycles where the column could accept data but none was offered.
// Assumes ROWS >= 2.
module ws_array_feeder #(
  parameter int WORD_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       vec_count,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [WORD_WIDTH-1:0]      w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ROWS*WORD_WIDTH-1:0] a_data,
  output logic [1:0]                 control,
  output logic [4*WORD_WIDTH-1:0]    d_in,
  output logic [ROWS*WORD_WIDTH-1:0] a_in,
  output logic [ROWS-1:0]            a_in_vld,
  output logic                       busy,
  output logic                       done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int PSUM_W = 4 * WORD_WIDTH;
  localparam int WC_W   = $clog2(ROWS + 1);
  localparam int DR_W   = (ROWS > 2) ? $clog2(ROWS) : 1;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_LOAD = 2'b01;
  localparam logic [1:0] CTRL_COMP = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t               state_q;
  logic [WC_W-1:0]      wcnt_q;
  logic [CNT_WIDTH-1:0] vcnt_q;
  logic [CNT_WIDTH-1:0] vec_q;
  logic [DR_W-1:0]      drain_q;
  logic                 w_ready_q;
  logic                 a_ready_q;
  logic [1:0]           control_q;
  logic [PSUM_W-1:0]    d_in_q;
  logic                 busy_q;
  logic                 done_q;

  logic w_accept;
  logic a_accept;

  // Handshakes use the registered ready, so acceptance matches what upstream saw.
  assign w_accept = w_valid & w_ready_q;
  assign a_accept = a_valid & a_ready_q;

  // Job sequencer: state, counters and all registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      vcnt_q    <= '0;
      vec_q     <= '0;
      drain_q   <= '0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      control_q <= CTRL_HOLD;
      d_in_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          control_q <= CTRL_HOLD;
          w_ready_q <= 1'b0;
          a_ready_q <= 1'b0;
          wcnt_q    <= '0;
          vcnt_q    <= '0;
          if (start) begin
            vec_q   <= vec_count;
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          // The first LOAD cycle is a setup cycle: ready rises one edge later.
          w_ready_q <= 1'b1;
          if (w_accept) begin
            control_q <= CTRL_LOAD;
            d_in_q    <= PSUM_W'(w_data);
            if (wcnt_q == WC_W'(ROWS - 1)) begin
              wcnt_q    <= WC_W'(ROWS);
              w_ready_q <= 1'b0;
              drain_q   <= '0;
              if (vec_q == '0) begin
                state_q <= S_DRAIN;
              end else begin
                state_q   <= S_COMPUTE;
                a_ready_q <= 1'b1;
              end
            end else begin
              wcnt_q <= wcnt_q + WC_W'(1);
            end
          end else begin
            // Bubble: hold code keeps the PEs still; d_in keeps its last value.
            control_q <= CTRL_HOLD;
          end
        end
        S_COMPUTE: begin
          control_q <= CTRL_COMP;
          d_in_q    <= '0;
          if (a_accept) begin
            vcnt_q <= vcnt_q + CNT_WIDTH'(1);
            if (vcnt_q + CNT_WIDTH'(1) == vec_q) begin
              state_q   <= S_DRAIN;
              a_ready_q <= 1'b0;
              drain_q   <= '0;
            end
          end
        end
        S_DRAIN: begin
          control_q <= CTRL_COMP;
          d_in_q    <= '0;
          if (drain_q == DR_W'(ROWS - 2)) begin
            state_q   <= S_IDLE;
            control_q <= CTRL_HOLD;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            drain_q <= drain_q + DR_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign w_ready = w_ready_q;
  assign a_ready = a_ready_q;
  assign control = control_q;
  assign d_in    = d_in_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Skew network: lane r is an (r+1)-deep register chain, so lane 0 shows a
  // vector right after its accept edge and lane r shows it r cycles later.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_lane
      logic [WORD_WIDTH-1:0] data_q [gi+1];
      logic                  vld_q  [gi+1];

      // Shift accepted lane data (or a zero bubble) one stage per cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j <= gi; j++) begin
            data_q[j] <= '0;
            vld_q[j]  <= 1'b0;
          end
        end else begin
          data_q[0] <= a_accept ? a_data[gi*WORD_WIDTH +: WORD_WIDTH] : '0;
          vld_q[0]  <= a_accept;
          for (int j = 1; j <= gi; j++) begin
            data_q[j] <= data_q[j-1];
            vld_q[j]  <= vld_q[j-1];
          end
        end
      end

      assign a_in[gi*WORD_WIDTH +: WORD_WIDTH] = data_q[gi];
      assign a_in_vld[gi]                      = vld_q[gi];
    end
  endgenerate

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_hit;

  assign stall_hit = ((state_q == S_LOAD) && w_ready_q && !w_valid) ||
                     ((state_q == S_COMPUTE) && a_ready_q && !a_valid);

  // Count cycles where the column could take data but upstream offered none.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      stall_q <= '0;
    end else if (stall_hit && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ws_array_feeder.sv
// tb_ws_array_feeder: directed jobs with a queue-based scoreboard. Stimulus
// pushes expected weight loads and per-lane activations (with the cycle they
// must appear); a negedge monitor pops and compares whenever the DUT shows
// control=01 or a valid lane.
module tb_ws_array_feeder;
  localparam int W  = 8;
  localparam int R  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [CW-1:0]   vec_count = '0;
  logic            w_valid = 1'b0;
  logic [W-1:0]    w_data = '0;
  logic            a_valid = 1'b0;
  logic [R*W-1:0]  a_data = '0;
  logic            w_ready, a_ready, busy, done;
  logic [1:0]      control;
  logic [4*W-1:0]  d_in;
  logic [R*W-1:0]  a_in;
  logic [R-1:0]    a_in_vld;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  ws_array_feeder #(.WORD_WIDTH(W), .ROWS(R), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_count(vec_count),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .control(control), .d_in(d_in), .a_in(a_in), .a_in_vld(a_in_vld),
    .busy(busy), .done(done)
`ifdef FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    int          lane;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t  ld_q[$];
  ev_t  ln_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b0;
  logic [W-1:0]  wt [4];
  logic [31:0]   vv [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consume scoreboard entries as the DUT presents them.
  always @(negedge clk) begin
    ev_t e;
    int  idx;
    if (mon_en) begin
      if (control == 2'b01) begin
        if (ld_q.size() == 0) begin
          chk("load_unexpected", 64'(control), 64'd0);
        end else begin
          e = ld_q.pop_front();
          chk("load_d_in", 64'(d_in), 64'(e.data));
          chk("load_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      for (int r = 0; r < R; r++) begin
        if (a_in_vld[r]) begin
          idx = -1;
          for (int j = 0; j < ln_q.size() && idx < 0; j++)
            if (ln_q[j].lane == r) idx = j;
          if (idx < 0) begin
            chk("lane_unexpected", 64'(a_in_vld[r]), 64'd0);
          end else begin
            e = ln_q[idx];
            ln_q.delete(idx);
            chk("lane_data", 64'(a_in[r*W +: W]), 64'(e.data));
            chk("lane_cycle", 64'(cyc), 64'(e.cyc));
          end
        end else begin
          chk("lane_bubble_zero", 64'(a_in[r*W +: W]), 64'd0);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_weights(input int nmax, input logic [5:0] pat, output int stalls);
    int   k;
    int   step;
    logic v;
    ev_t  e;
    k = 0;
    step = 0;
    stalls = 0;
    chk("w_ready_setup", 64'(w_ready), 64'd0);
    tick();
    while (k < nmax && step < 40) begin
      chk("w_ready_load", 64'(w_ready), 64'd1);
      v = (step < 6) ? pat[step] : 1'b1;
      w_valid = v;
      w_data  = v ? wt[k] : 8'hEE;
      if (v) begin
        e.lane = 0;
        e.data = 32'(wt[k]);
        e.cyc  = cyc + 1;
        ld_q.push_back(e);
      end else begin
        stalls++;
      end
      tick();
      step++;
      chk("control_load", 64'(control), v ? 64'd1 : 64'd0);
      if (!v && k > 0) chk("d_in_hold", 64'(d_in), 64'(wt[k-1]));
      if (v) k++;
    end
    w_valid = 1'b0;
    w_data  = '0;
    if (k == R) chk("w_ready_after", 64'(w_ready), 64'd0);
  endtask

  task automatic feed_vectors(input int n, input int bub, input int st_at, output int stalls);
    int  i;
    int  step;
    ev_t e;
    i = 0;
    step = 0;
    stalls = 0;
    while (i < n && step < 64) begin
      chk("a_ready_compute", 64'(a_ready), 64'd1);
      if (step == bub) begin
        a_valid = 1'b0;
        a_data  = 32'hDEADBEEF;
        stalls++;
      end else begin
        a_valid = 1'b1;
        a_data  = vv[i];
        for (int r = 0; r < R; r++) begin
          e.lane = r;
          e.data = 32'(vv[i][r*W +: W]);
          e.cyc  = cyc + 1 + r;
          ln_q.push_back(e);
        end
        i++;
      end
      if (step == st_at) begin
        start     = 1'b1;
        vec_count = 8'd7;
      end
      tick();
      step++;
      start     = 1'b0;
      vec_count = '0;
      chk("control_compute", 64'(control), 64'd2);
      chk("d_in_compute", 64'(d_in), 64'd0);
    end
    a_valid = 1'b0;
    a_data  = '0;
    chk("a_ready_after", 64'(a_ready), 64'd0);
  endtask

  task automatic wait_done(input int exp_cyc);
    int lim;
    lim = 0;
    while (done !== 1'b1 && lim < 300) begin
      chk("a_ready_drain", 64'(a_ready), 64'd0);
      tick();
      lim++;
      if (done !== 1'b1) chk("control_drain", 64'(control), 64'd2);
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_cycle", 64'(cyc), 64'(exp_cyc));
    chk("busy_end", 64'(busy), 64'd0);
    chk("control_end", 64'(control), 64'd0);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic run_job(input int id, input int v, input logic [5:0] pat,
                         input int cbub, input int st_at, input int exp_stall);
    int t;
    int ls;
    int cs;
    int base;
    base = done_cnt;
    start     = 1'b1;
    vec_count = CW'(v);
    tick();
    start     = 1'b0;
    vec_count = '0;
    t = cyc;
    chk("busy_start", 64'(busy), 64'd1);
    load_weights(R, pat, ls);
    cs = 0;
    if (v > 0) feed_vectors(v, cbub, st_at, cs);
    else chk("a_ready_v0", 64'(a_ready), 64'd0);
    wait_done(t + 2 * R + v + exp_stall);
    chk("done_count", 64'(done_cnt - base), 64'd1);
    chk("load_q_empty", 64'(ld_q.size()), 64'd0);
    chk("lane_q_empty", 64'(ln_q.size()), 64'd0);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
    $display("job %0d: vec_count=%0d weight stalls=%0d vector stalls=%0d", id, v, ls, cs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ls;
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_control", 64'(control), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_d_in", 64'(d_in), 64'd0);
    chk("rst_a_in", 64'(a_in), 64'd0);
    chk("rst_a_in_vld", 64'(a_in_vld), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Abort mid-LOAD after two weights
    start     = 1'b1;
    vec_count = 8'd1;
    tick();
    start     = 1'b0;
    vec_count = '0;
    wt = '{8'd21, 8'd22, 8'd23, 8'd24};
    load_weights(2, 6'h3F, ls);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_control", 64'(control), 64'd0);
    chk("abort_a_in", 64'(a_in), 64'd0);
    chk("abort_w_ready", 64'(w_ready), 64'd0);
    chk("abort_d_in", 64'(d_in), 64'd0);
    chk("abort_load_q", 64'(ld_q.size()), 64'd0);
    $display("abort: reset applied after 2 weights");

    // Fresh job after abort
    wt = '{8'd10, 8'd11, 8'd12, 8'd13};
    vv[0] = 32'h04030201;
    vv[1] = 32'h44332211;
    run_job(1, 2, 6'h3F, -1, -1, 0);

    // Weights 3,4,5,6 and skewed vector {8,7,6,5}
    wt = '{8'd3, 8'd4, 8'd5, 8'd6};
    vv[0] = 32'h08070605;
    run_job(2, 1, 6'h3F, -1, -1, 0);

    // w_valid pattern 1,0,1,0,1,1 with a full-scale weight
    wt = '{8'h81, 8'h42, 8'hFF, 8'h01};
    vv[0] = 32'hA0B0C0D0;
    vv[1] = 32'h0F0E0D0C;
    run_job(3, 2, 6'b110101, -1, -1, 2);

    // vec_count = 0: load then drain only
    wt = '{8'd7, 8'd8, 8'd9, 8'd10};
    run_job(4, 0, 6'h3F, -1, -1, 0);

    // start re-asserted in COMPUTE, plus one vector bubble
    wt = '{8'd1, 8'd2, 8'd3, 8'd4};
    vv[0] = 32'h11121314;
    vv[1] = 32'h21222324;
    vv[2] = 32'h31323334;
    run_job(5, 3, 6'h3F, 2, 1, 1);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
